// File: rtl/mmr_pkg.sv
// -----------------------------------------------------------------------------
// mmr_pkg
// Shared definitions for the K-modular-redundant scrubbed register file.
//   scrub_state_t : background scrubber state (WAIT between passes, SCRUB walking)
//   vote_maj3     : single-bit 2-of-3 majority
//   k_mmr_legal   : elaboration-time check of the redundancy factor (1 or 3)
// -----------------------------------------------------------------------------
package mmr_pkg;

    typedef enum logic {
        WAIT  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_t;

    function automatic logic vote_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic bit k_mmr_legal(input int unsigned k);
        return (k == 1) || (k == 3);
    endfunction

endpackage

// File: rtl/mmr_word_voter.sv
// -----------------------------------------------------------------------------
// mmr_word_voter
// Combinational N-bit voter over K redundant copies of one word.
//   words    in  [K][N]  the K copies of the word
//   voted    out [N]     bitwise majority (K=3) or copy 0 (K=1)
//   mismatch out 1       at least one copy differs from another (always 0 for K=1)
// -----------------------------------------------------------------------------
module mmr_word_voter
    import mmr_pkg::*;
#(
    parameter int unsigned K = 3,
    parameter int unsigned N = 16
) (
    input  logic [K-1:0][N-1:0] words,
    output logic [N-1:0]        voted,
    output logic                mismatch
);

    generate
        if (K == 3) begin : gen_maj3
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    voted[i] = vote_maj3(words[0][i], words[1][i], words[2][i]);
                end
            end

            // Two pairwise compares cover all three copies: if 0==1 and 1==2 then 0==2.
            assign mismatch = (words[0] != words[1]) || (words[1] != words[2]);
        end else begin : gen_single
            assign voted    = words[0];
            assign mismatch = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mmr_scrub_register_file.sv
// -----------------------------------------------------------------------------
// mmr_scrub_register_file
// DEPTH x N register file stored in K_MMR independent copies, with a voted,
// registered read port per copy and a background scrubber that rewrites every
// word whose copies disagree, so single-event upsets cannot accumulate.
//
// Ports
//   clk_i           in   1                clock
//   rst_i           in   1                synchronous active-high reset
//   wr_en_i         in   [K_MMR]          write enable per copy
//   wr_addr_i       in   [K_MMR][ADDR_W]  write address per copy
//   wr_data_i       in   [K_MMR][N]       write data per copy
//   rd_addr_i       in   [K_MMR][ADDR_W]  read address per copy
//   rd_data_o       out  [K_MMR][N]       voted read data per copy, 1-cycle latency
//   scrub_start_i   in   1                request an immediate scrub pass (level)
//   scrub_busy_o    out  1                high while a scrub pass is in progress
//   cnt_clear_i     in   1                clear mismatch_cnt_o (wins over increment)
//   mismatch_cnt_o  out  [CNT_W]          saturating count of scrub-corrected words
//   mismatch_o      out  1                pulse: a read or the scrubber saw copies disagree
//
// The scrub FSM, its pointer and the period counter exist once; only the data
// storage is replicated.
// -----------------------------------------------------------------------------
module mmr_scrub_register_file
    import mmr_pkg::*;
#(
    parameter  int unsigned    K_MMR        = 3,
    parameter  int unsigned    N            = 16,
    parameter  int unsigned    DEPTH        = 16,
    parameter  logic [N-1:0]   RESET_VALUE  = '0,
    parameter  int unsigned    SCRUB_PERIOD = 1024,
    parameter  int unsigned    CNT_W        = 16,
    localparam int unsigned    ADDR_W       = $clog2(DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [K_MMR-1:0]               wr_en_i,
    input  logic [K_MMR-1:0][ADDR_W-1:0]   wr_addr_i,
    input  logic [K_MMR-1:0][N-1:0]        wr_data_i,
    input  logic [K_MMR-1:0][ADDR_W-1:0]   rd_addr_i,
    output logic [K_MMR-1:0][N-1:0]        rd_data_o,
    input  logic                           scrub_start_i,
    output logic                           scrub_busy_o,
    input  logic                           cnt_clear_i,
    output logic [CNT_W-1:0]               mismatch_cnt_o,
    output logic                           mismatch_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    localparam bit K_MMR_OK = k_mmr_legal(K_MMR);

    generate
        if (!K_MMR_OK) begin : gen_bad_k_mmr
            $error("mmr_scrub_register_file: K_MMR must be 1 or 3");
        end
        if (DEPTH < 2) begin : gen_bad_depth
            $error("mmr_scrub_register_file: DEPTH must be at least 2");
        end
    endgenerate

    // Period counter only needs to hold SCRUB_PERIOD; keep at least one bit.
    localparam int unsigned       PER_W      = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD + 1) : 1;
    localparam logic [PER_W-1:0]  PER_RELOAD = PER_W'(SCRUB_PERIOD);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam bit                AUTO_SCRUB = (SCRUB_PERIOD != 0);

    // -------------------------------------------------------------------------
    // Storage: K_MMR copies of DEPTH words
    // -------------------------------------------------------------------------
    logic [N-1:0] mem [K_MMR][DEPTH];

    // -------------------------------------------------------------------------
    // Scrubber control state
    // -------------------------------------------------------------------------
    scrub_state_t       state;
    logic               busy;
    logic [ADDR_W-1:0]  ptr;
    logic [PER_W-1:0]   period_cnt;

    // -------------------------------------------------------------------------
    // Read voters: port k votes across all copies at its own address
    // -------------------------------------------------------------------------
    logic [K_MMR-1:0][N-1:0] rd_words [K_MMR];
    logic [N-1:0]            rd_vote  [K_MMR];
    logic [K_MMR-1:0]        rd_mis;

    // NOTE: every always_comb output gets a full assignment on every path, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < K_MMR; k++) begin
            for (int j = 0; j < K_MMR; j++) begin
                rd_words[k][j] = mem[j][rd_addr_i[k]];
            end
        end
    end

    generate
        for (genvar k = 0; k < K_MMR; k++) begin : gen_rd_voter
            mmr_word_voter #(
                .K (K_MMR),
                .N (N)
            ) u_rd_voter (
                .words    (rd_words[k]),
                .voted    (rd_vote[k]),
                .mismatch (rd_mis[k])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scrub voter: all copies at the scrub pointer
    // -------------------------------------------------------------------------
    logic [K_MMR-1:0][N-1:0] scrub_words;
    logic [N-1:0]            scrub_vote;
    logic                    scrub_mis;
    logic                    scrub_stall;
    logic                    scrub_fix;

    always_comb begin
        for (int j = 0; j < K_MMR; j++) begin
            scrub_words[j] = mem[j][ptr];
        end
    end

    mmr_word_voter #(
        .K (K_MMR),
        .N (N)
    ) u_scrub_voter (
        .words    (scrub_words),
        .voted    (scrub_vote),
        .mismatch (scrub_mis)
    );

    // A user write to any copy of the word under the scrub pointer takes
    // precedence: the scrubber skips its write and revisits the same word.
    always_comb begin
        scrub_stall = 1'b0;
        for (int j = 0; j < K_MMR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j] == ptr)) begin
                scrub_stall = 1'b1;
            end
        end
    end

    assign scrub_fix = (state == SCRUB) && !scrub_stall && scrub_mis;

    // -------------------------------------------------------------------------
    // Storage update. The scrub write and user writes never hit the same word
    // in one cycle because of the stall, so their order here is irrelevant.
    // -------------------------------------------------------------------------
    // NOTE: the array is reset explicitly because every word must come up at RESET_VALUE; this forces flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < K_MMR; j++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem[j][a] <= RESET_VALUE;
                end
            end
        end else begin
            for (int j = 0; j < K_MMR; j++) begin
                if (scrub_fix) begin
                    mem[j][ptr] <= scrub_vote;
                end
                if (wr_en_i[j]) begin
                    mem[j][wr_addr_i[j]] <= wr_data_i[j];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scrub FSM
    //   WAIT : count idle cycles down; leave on reaching 1 or on scrub_start_i.
    //   SCRUB: visit one word per non-stalled cycle; return to WAIT after the last.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= WAIT;
            busy       <= 1'b0;
            ptr        <= '0;
            period_cnt <= PER_RELOAD;
        end else begin
            case (state)
                WAIT: begin
                    if (scrub_start_i || (AUTO_SCRUB && (period_cnt == PER_W'(1)))) begin
                        state <= SCRUB;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end else if (AUTO_SCRUB) begin
                        period_cnt <= period_cnt - PER_W'(1);
                    end
                end
                SCRUB: begin
                    if (!scrub_stall) begin
                        if (ptr == LAST_ADDR) begin
                            state      <= WAIT;
                            busy       <= 1'b0;
                            period_cnt <= PER_RELOAD;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= WAIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign scrub_busy_o = busy;

    // -------------------------------------------------------------------------
    // Registered read data, mismatch pulse and saturating correction counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < K_MMR; k++) begin
                rd_data_o[k] <= RESET_VALUE;
            end
            mismatch_o     <= 1'b0;
            mismatch_cnt_o <= '0;
        end else begin
            for (int k = 0; k < K_MMR; k++) begin
                rd_data_o[k] <= rd_vote[k];
            end
            mismatch_o <= (|rd_mis) || scrub_fix;
            if (cnt_clear_i) begin
                mismatch_cnt_o <= '0;
            end else if (scrub_fix && (mismatch_cnt_o != '1)) begin
                mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmr_scrub_register_file.sv
// -----------------------------------------------------------------------------
// tb_mmr_scrub_register_file
// Directed vector table, hand-written scrub corner cases and a randomized run,
// all checked against expected values computed inside this bench.
// -----------------------------------------------------------------------------
module tb_mmr_scrub_register_file;

    localparam int          K     = 3;
    localparam int          N     = 16;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam int          P     = 64;
    localparam int          CW    = 2;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam logic [15:0] RV    = 16'h3C5A;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [K-1:0]             wr_en_i;
    logic [K-1:0][AW-1:0]     wr_addr_i;
    logic [K-1:0][N-1:0]      wr_data_i;
    logic [K-1:0][AW-1:0]     rd_addr_i;
    logic [K-1:0][N-1:0]      rd_data_o;
    logic                     scrub_start_i;
    logic                     scrub_busy_o;
    logic                     cnt_clear_i;
    logic [CW-1:0]            mismatch_cnt_o;
    logic                     mismatch_o;

    always #5 clk_i = ~clk_i;

    mmr_scrub_register_file #(
        .K_MMR        (K),
        .N            (N),
        .DEPTH        (DEPTH),
        .RESET_VALUE  (RV),
        .SCRUB_PERIOD (P),
        .CNT_W        (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .scrub_start_i  (scrub_start_i),
        .scrub_busy_o   (scrub_busy_o),
        .cnt_clear_i    (cnt_clear_i),
        .mismatch_cnt_o (mismatch_cnt_o),
        .mismatch_o     (mismatch_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dut=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [15:0] m_mem [K][DEPTH];
    logic [15:0] m_rd  [K];
    bit          m_mis;
    bit          m_busy;
    int          m_ptr;
    int          m_idle;
    int          m_cnt;

    // Majority by counting ones per bit position.
    function automatic logic [15:0] m_vote(input int a);
        logic [15:0] v;
        for (int b = 0; b < N; b++) begin
            int ones;
            ones = int'(m_mem[0][a][b]) + int'(m_mem[1][a][b]) + int'(m_mem[2][a][b]);
            v[b] = (ones >= 2);
        end
        return v;
    endfunction

    function automatic bit m_differ(input int a);
        return !((m_mem[0][a] == m_mem[1][a]) && (m_mem[1][a] == m_mem[2][a]));
    endfunction

    task automatic model_step();
        logic [15:0] nxt [K][DEPTH];
        bit          read_dis;
        bit          fix;
        bit          hit;
        logic [15:0] v;
        if (rst_i) begin
            for (int c = 0; c < K; c++) begin
                for (int a = 0; a < DEPTH; a++) m_mem[c][a] = RV;
                m_rd[c] = RV;
            end
            m_mis  = 0;
            m_busy = 0;
            m_ptr  = 0;
            m_idle = P;
            m_cnt  = 0;
            return;
        end
        read_dis = 0;
        fix      = 0;
        for (int k = 0; k < K; k++) begin
            m_rd[k] = m_vote(int'(rd_addr_i[k]));
            if (m_differ(int'(rd_addr_i[k]))) read_dis = 1;
        end
        nxt = m_mem;
        if (m_busy) begin
            hit = 0;
            for (int k = 0; k < K; k++)
                if (wr_en_i[k] && (int'(wr_addr_i[k]) == m_ptr)) hit = 1;
            if (!hit) begin
                if (m_differ(m_ptr)) begin
                    fix = 1;
                    v   = m_vote(m_ptr);
                    for (int c = 0; c < K; c++) nxt[c][m_ptr] = v;
                end
                if (m_ptr == DEPTH - 1) begin
                    m_busy = 0;
                    m_idle = P;
                end else begin
                    m_ptr++;
                end
            end
        end else if (scrub_start_i || m_idle == 1) begin
            m_busy = 1;
            m_ptr  = 0;
        end else begin
            m_idle--;
        end
        for (int c = 0; c < K; c++)
            if (wr_en_i[c]) nxt[c][wr_addr_i[c]] = wr_data_i[c];
        m_mem = nxt;
        if (cnt_clear_i) m_cnt = 0;
        else if (fix && m_cnt < CMAX) m_cnt++;
        m_mis = read_dis || fix;
    endtask

    // One clock: advance the model on the current inputs, then compare #1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < K; k++) check($sformatf("m_rd%0d", k), rd_data_o[k], m_rd[k]);
        check("m_mismatch", mismatch_o, m_mis);
        check("m_busy", scrub_busy_o, m_busy);
        check("m_cnt", mismatch_cnt_o, m_cnt);
    endtask

    task automatic set_rd(input int a);
        for (int k = 0; k < K; k++) rd_addr_i[k] = AW'(a);
    endtask

    task automatic set_wr(input logic [2:0] en, input int a, input logic [15:0] d);
        wr_en_i = en;
        for (int k = 0; k < K; k++) begin
            wr_addr_i[k] = AW'(a);
            wr_data_i[k] = d;
        end
    endtask

    task automatic read_expect(input string name, input int a, input logic [15:0] exp, input bit exp_mis);
        set_rd(a);
        tick();
        for (int k = 0; k < K; k++) check($sformatf("%s_rd%0d", name, k), rd_data_o[k], exp);
        check({name, "_mis"}, mismatch_o, exp_mis);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [2:0]  en;
        int          addr;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] exp;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n;
        int e;

        vecs[0] = '{3'b111,  5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[1] = '{3'b010,  5, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 1'b1};
        vecs[2] = '{3'b001,  9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3C5A, 1'b1};
        vecs[3] = '{3'b110,  9, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b1};
        vecs[4] = '{3'b001,  9, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b0};
        vecs[5] = '{3'b011,  0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b1};
        vecs[6] = '{3'b100, 15, 16'h8001, 16'h8001, 16'h8001, 16'h3C5A, 1'b1};
        vecs[7] = '{3'b000,  3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3C5A, 1'b0};
        vecs[8] = '{3'b111,  7, 16'h00FF, 16'h0F0F, 16'h3333, 16'h033F, 1'b1};

        rst_i         = 1'b1;
        wr_en_i       = '0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        rd_addr_i     = '0;
        scrub_start_i = 1'b0;
        cnt_clear_i   = 1'b0;
        tick();
        rst_i = 1'b0;

        // Reset state: every word of every copy reads back as RESET_VALUE.
        for (int a = 0; a < DEPTH; a++) read_expect("reset", a, RV, 1'b0);
        check("reset_cnt", mismatch_cnt_o, 0);
        check("reset_busy", scrub_busy_o, 0);

        // Vector table: write cycle, then read cycle.
        for (int i = 0; i < 9; i++) begin
            wr_en_i = vecs[i].en;
            for (int k = 0; k < K; k++) wr_addr_i[k] = AW'(vecs[i].addr);
            wr_data_i[0] = vecs[i].d0;
            wr_data_i[1] = vecs[i].d1;
            wr_data_i[2] = vecs[i].d2;
            set_rd(vecs[i].addr);
            tick();
            if (i == 0) check("raw_returns_old", rd_data_o[0], RV);
            wr_en_i = '0;
            read_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].exp_mis);
        end

        // Scrub pass corrects words 0, 5, 7 and 15; the 2-bit counter saturates at 3.
        scrub_start_i = 1'b1;
        tick();
        scrub_start_i = 1'b0;
        n = 0;
        while (scrub_busy_o && n < 40) begin
            n++;
            tick();
        end
        check("scrub_len", n, DEPTH);
        check("cnt_saturated", mismatch_cnt_o, CMAX);
        read_expect("post5",  5, 16'hA5A5, 1'b0);
        read_expect("post7",  7, 16'h033F, 1'b0);
        read_expect("post15", 15, 16'h3C5A, 1'b0);
        read_expect("post0",  0, 16'h1234, 1'b0);

        // Per-copy addresses: upset copy0 of word 0 and copy2 of word 2 in one cycle.
        wr_en_i      = 3'b101;
        wr_addr_i[0] = AW'(0);
        wr_addr_i[2] = AW'(2);
        wr_data_i[0] = 16'h0000;
        wr_data_i[2] = 16'h0000;
        tick();
        wr_en_i = '0;
        // Clear coincides with the correction of word 0: clear wins.
        scrub_start_i = 1'b1;
        tick();
        scrub_start_i = 1'b0;
        cnt_clear_i   = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check("clear_priority", mismatch_cnt_o, 0);
        check("fix_pulse", mismatch_o, 1);
        n = 0;
        while (scrub_busy_o && n < 40) begin
            n++;
            tick();
        end
        check("cnt_after_clear", mismatch_cnt_o, 1);
        read_expect("fixed2", 2, 16'h3C5A, 1'b0);

        // Collision: user write to the word under the pointer stalls the pass one cycle.
        scrub_start_i = 1'b1;
        tick();
        scrub_start_i = 1'b0;
        n = 0;
        while (scrub_busy_o && n < 40) begin
            n++;
            if (n == 4) set_wr(3'b111, 3, 16'hBEEF);
            else wr_en_i = '0;
            tick();
        end
        wr_en_i = '0;
        check("collision_len", n, DEPTH + 1);
        read_expect("collision_data", 3, 16'hBEEF, 1'b0);

        // Reset in the middle of a pass, with a write that must be discarded.
        set_wr(3'b010, 12, 16'h0000);
        tick();
        wr_en_i = '0;
        scrub_start_i = 1'b1;
        tick();
        scrub_start_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_i = 1'b1;
        set_wr(3'b111, 12, 16'h1111);
        tick();
        rst_i   = 1'b0;
        wr_en_i = '0;
        check("midreset_busy", scrub_busy_o, 0);
        for (int a = 0; a < DEPTH; a++) read_expect("midreset", a, RV, 1'b0);
        e = DEPTH;
        while (!scrub_busy_o && e < 200) begin
            tick();
            e++;
        end
        check("auto_scrub_edge", e, P);
        n = 0;
        while (scrub_busy_o && n < 40) begin
            n++;
            tick();
        end
        check("auto_scrub_len", n, DEPTH);

        // Randomized run against the model; writes are sometimes aimed at the scrub pointer.
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < K; k++) begin
                wr_en_i[k]   = ($urandom_range(0, 3) == 0);
                wr_addr_i[k] = ($urandom_range(0, 3) == 0) ? AW'(m_ptr) : AW'($urandom_range(0, DEPTH - 1));
                wr_data_i[k] = 16'($urandom);
                rd_addr_i[k] = AW'($urandom_range(0, DEPTH - 1));
            end
            scrub_start_i = ($urandom_range(0, 99) == 0);
            cnt_clear_i   = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
